// File: rtl/load_scoreboard_hazard_unit_if.sv
// ID/EX hazard bundle between pipeline control and the load scoreboard.
// HAZARD_STALL_STATS_EN adds the stall statistics counters.
interface load_scoreboard_hazard_unit_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [1:0]       op1_selector;
    logic [1:0]       op2_selector;
    logic [1:0]       how_many_ops;
    logic             id_is_load;
    logic             ex_load_valid;
    logic [REG_W-1:0] ex_load_dst;
    logic             mem_ready;
    logic             PC_write;
    logic             IF_ID_write;
    logic             flush;
    logic             valid;
    logic [1:0]       load_useA;
    logic [1:0]       load_useB;
    logic             sb_full;
`ifdef HAZARD_STALL_STATS_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      struct_stall_cycles;

    modport master (
        output rs, rt, rd,
        output op1_selector, op2_selector, how_many_ops,
        output id_is_load, ex_load_valid, ex_load_dst, mem_ready,
        input  PC_write, IF_ID_write, flush, valid,
        input  load_useA, load_useB, sb_full,
        input  stall_cycles, struct_stall_cycles
    );

    modport slave (
        input  rs, rt, rd,
        input  op1_selector, op2_selector, how_many_ops,
        input  id_is_load, ex_load_valid, ex_load_dst, mem_ready,
        output PC_write, IF_ID_write, flush, valid,
        output load_useA, load_useB, sb_full,
        output stall_cycles, struct_stall_cycles
    );
`else
    modport master (
        output rs, rt, rd,
        output op1_selector, op2_selector, how_many_ops,
        output id_is_load, ex_load_valid, ex_load_dst, mem_ready,
        input  PC_write, IF_ID_write, flush, valid,
        input  load_useA, load_useB, sb_full
    );

    modport slave (
        input  rs, rt, rd,
        input  op1_selector, op2_selector, how_many_ops,
        input  id_is_load, ex_load_valid, ex_load_dst, mem_ready,
        output PC_write, IF_ID_write, flush, valid,
        output load_useA, load_useB, sb_full
    );
`endif
endinterface

// File: rtl/load_scoreboard_hazard_unit.sv
// Multi-entry load scoreboard: load-use stall, bubble and forward selects.
// HAZARD_STALL_STATS_EN adds saturating stall_cycles/struct_stall_cycles.
module load_scoreboard_hazard_unit #(
    parameter int REG_W    = 5,
    parameter int DEPTH    = 4,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic rst,
    load_scoreboard_hazard_unit_if.slave hz
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dst;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    entry_t sb_q [DEPTH];

    logic [DEPTH-1:0] v_vec;
    logic [DEPTH-1:0] done;
    logic [DEPTH-1:0] pend;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            v_vec[i] = sb_q[i].v;
            done[i]  = sb_q[i].v && (sb_q[i].cnt == CNT_W'(1))
                       && hz.mem_ready;
            pend[i]  = sb_q[i].v && !done[i];
        end
    end

    logic [REG_W-1:0] op1_r;
    logic [REG_W-1:0] op2_r;
    logic             op1_on;
    logic             op2_on;
    logic             chk1;
    logic             chk2;

    assign chk1 = (hz.how_many_ops == 2'b01) || (hz.how_many_ops == 2'b10);
    assign chk2 = (hz.how_many_ops == 2'b10);

    always_comb begin
        op1_r = '0;
        unique case (1'b1)
            hz.op1_selector == 2'b00: op1_r = hz.rs;
            hz.op1_selector == 2'b01: op1_r = hz.rt;
            hz.op1_selector == 2'b10: op1_r = hz.rd;
            default:                  op1_r = '0;
        endcase
        op2_r = '0;
        unique case (1'b1)
            hz.op2_selector == 2'b00: op2_r = hz.rs;
            hz.op2_selector == 2'b01: op2_r = hz.rt;
            hz.op2_selector == 2'b10: op2_r = hz.rd;
            default:                  op2_r = '0;
        endcase
    end

    // Selector 11 decodes to r0, which never matches, so it drops out here.
    assign op1_on = chk1 && (op1_r != '0);
    assign op2_on = chk2 && (op2_r != '0);

    logic p1, d1, p2, d2;

    always_comb begin
        p1 = 1'b0;
        d1 = 1'b0;
        p2 = 1'b0;
        d2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sb_q[i].dst == op1_r) begin
                p1 = p1 | pend[i];
                d1 = d1 | done[i];
            end
            if (sb_q[i].dst == op2_r) begin
                p2 = p2 | pend[i];
                d2 = d2 | done[i];
            end
        end
    end

    logic op_stall;
    logic struct_stall;
    logic stall;

    assign op_stall     = (op1_on && p1) || (op2_on && p2);
    assign struct_stall = hz.id_is_load && hz.sb_full;
    assign stall        = op_stall || struct_stall;

    assign hz.sb_full     = &v_vec;
    assign hz.PC_write    = !stall;
    assign hz.IF_ID_write = !stall;
    assign hz.flush       = stall;
    assign hz.valid       = !stall;
    assign hz.load_useA   = (!stall && op1_on && d1) ? 2'b10 : 2'b00;
    assign hz.load_useB   = (!stall && op2_on && d2) ? 2'b10 : 2'b00;

    // Free slot is chosen from start-of-cycle state: a slot retiring now
    // stays unavailable until the next cycle.
    logic             alloc_hit;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc;

    always_comb begin
        alloc_hit = 1'b0;
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!sb_q[i].v) begin
                alloc_hit = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign alloc = hz.ex_load_valid && (hz.ex_load_dst != '0) && alloc_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sb_q[i].v && hz.mem_ready) begin
                    sb_q[i].cnt <= sb_q[i].cnt - CNT_W'(1);
                    if (done[i]) begin
                        sb_q[i].v <= 1'b0;
                    end
                end
                if (alloc && (alloc_idx == IDX_W'(i))) begin
                    sb_q[i].v   <= 1'b1;
                    sb_q[i].dst <= hz.ex_load_dst;
                    sb_q[i].cnt <= CNT_W'(LOAD_LAT);
                end
            end
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] sstall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            sstall_q <= '0;
        end else begin
            if (stall && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (struct_stall && !op_stall
                && (sstall_q != 32'hFFFF_FFFF)) begin
                sstall_q <= sstall_q + 32'd1;
            end
        end
    end

    assign hz.stall_cycles        = stall_q;
    assign hz.struct_stall_cycles = sstall_q;
`endif

endmodule
